// File: rtl/dmem_resp_pkg.sv
// Shared types and defaults for the dmem_resp data-memory responder.
// Optional byte-enable support is selected with the DMEM_RESP_BE_EN macro.
package dmem_resp_pkg;

  localparam int          WORD_W         = 32;
  localparam int          BE_W           = WORD_W / 8;
  localparam int          DEF_DEPTH_LOG2 = 8;
  localparam logic [31:0] DEF_BASE_ADDR  = 32'h1001_0000;
  localparam int          CNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte offset of a request relative to word 0; wraps for addresses below the base.
  function automatic logic [31:0] word_off(input logic [31:0] addr, input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
// The BE lanes exist only when DMEM_RESP_BE_EN is defined.
interface dmem_resp_if;
  import dmem_resp_pkg::*;

  // Handshake: RD/W are held by the master until READY; the slave pulses READY
  // for one cycle (with ERR on a rejected request) and ignores RD/W until then.
  logic              RD;
  logic              W;
  logic [31:0]       ADDR;
  logic [WORD_W-1:0] DIN;
  logic [WORD_W-1:0] DOUT;
  logic              READY;
  logic              ERR;
`ifdef DMEM_RESP_BE_EN
  logic [BE_W-1:0]   BE;

  modport master (output RD, W, ADDR, DIN, BE, input DOUT, READY, ERR);
  modport slave  (input RD, W, ADDR, DIN, BE, output DOUT, READY, ERR);
`else
  modport master (output RD, W, ADDR, DIN, input DOUT, READY, ERR);
  modport slave  (input RD, W, ADDR, DIN, output DOUT, READY, ERR);
`endif

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with byte-lane write enables and a registered read.
// Kept as its own module so a vendor memory macro can be dropped in.
module dmem_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Read-first: a write in the same cycle is not visible on rdata until the next read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: captures a load/store, waits WAIT_CYC cycles, then
// completes with a one-cycle READY/ERR pulse. Byte enables need DMEM_RESP_BE_EN.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
  parameter int          WAIT_CYC   = 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  dmem_resp_if.slave       bus,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0]       IDLE     = ST_IDLE;
  localparam logic [1:0]       WAIT     = ST_WAIT;
  localparam logic [1:0]       DONE     = ST_DONE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [31:0]           addr_q;
  logic [WORD_W-1:0]     din_q;
  logic                  op_w_q;
  logic                  both_q;
  logic [BE_W-1:0]       be_q;
  logic [WORD_W-1:0]     dout_hold;

  logic [31:0]           off_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] idx_live;
  logic                  misalign;
  logic                  out_of_range;
  logic                  be_err;
  logic                  err;
  logic                  load_ok;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [BE_W-1:0]       ram_be;
  logic [WORD_W-1:0]     ram_rdata;
  logic [BE_W-1:0]       be_in;

`ifdef DMEM_RESP_BE_EN
  assign be_in  = bus.BE;
  assign be_err = op_w_q && (be_q == '0);
  assign ram_be = be_q;
`else
  assign be_in  = '1;
  assign be_err = 1'b0;
  assign ram_be = '1;
`endif

  // Decode of the captured request; the range check covers wrap-around below the base.
  assign off_q        = word_off(addr_q, BASE_ADDR);
  assign idx_q        = DEPTH_LOG2'(off_q >> 2);
  assign misalign     = (addr_q[1:0] != 2'b00);
  assign out_of_range = ((off_q >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign err          = misalign | out_of_range | both_q | be_err;

  // The RAM reads the live address while idle so the word is ready even with no wait states.
  assign idx_live = DEPTH_LOG2'(word_off(bus.ADDR, BASE_ADDR) >> 2);
  assign ram_addr = (state == IDLE) ? idx_live : idx_q;

  assign load_ok = (state == DONE) && !op_w_q && !err;
  assign ram_we  = (state == DONE) && op_w_q && !err && RSTn;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      op_w_q    <= 1'b0;
      both_q    <= 1'b0;
      be_q      <= '0;
      dout_hold <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.RD || bus.W) begin
            addr_q <= bus.ADDR;
            din_q  <= bus.DIN;
            op_w_q <= bus.W;
            both_q <= bus.RD && bus.W;
            be_q   <= be_in;
            cnt    <= '0;
            state  <= (WAIT_CYC == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE: begin
          if (load_ok) dout_hold <= ram_rdata;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmem_ram #(
    .AW (DEPTH_LOG2),
    .DW (WORD_W)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (din_q),
    .rdata (ram_rdata)
  );

  assign bus.READY = (state == DONE);
  assign bus.ERR   = (state == DONE) && err;
  assign bus.DOUT  = load_ok ? ram_rdata : dout_hold;
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: a WAIT_CYC=1 instance driven from a vector table and a
// WAIT_CYC=3 instance driven by hand-written busy/latency sequences.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int OP_RD   = 0;
  localparam int OP_W    = 1;
  localparam int OP_BOTH = 2;
  localparam int LAT [2] = '{2, 4};

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rd_d [2];
  logic        w_d [2];
  logic [31:0] addr_d [2];
  logic [31:0] din_d [2];
  logic [3:0]  be_d [2];
  logic        rdy [2];
  logic        err_o [2];
  logic [31:0] dout_o [2];
  logic [1:0]  st_o [2];

  logic [32:0] exp_q [$];
  vec_t        vt [32];
  int          nv = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          pulses [2] = '{0, 0};
  int          exp_pulses [2] = '{0, 0};

  dmem_resp_if bus0 ();
  dmem_resp_if bus1 ();

  assign bus0.RD   = rd_d[0];
  assign bus0.W    = w_d[0];
  assign bus0.ADDR = addr_d[0];
  assign bus0.DIN  = din_d[0];
  assign bus1.RD   = rd_d[1];
  assign bus1.W    = w_d[1];
  assign bus1.ADDR = addr_d[1];
  assign bus1.DIN  = din_d[1];
`ifdef DMEM_RESP_BE_EN
  assign bus0.BE   = be_d[0];
  assign bus1.BE   = be_d[1];
`endif
  assign rdy[0]    = bus0.READY;
  assign err_o[0]  = bus0.ERR;
  assign dout_o[0] = bus0.DOUT;
  assign rdy[1]    = bus1.READY;
  assign err_o[1]  = bus1.ERR;
  assign dout_o[1] = bus1.DOUT;

  dmem_resp #(.WAIT_CYC(1)) u_dut1 (
    .CLK       (clk),
    .RSTn      (rstn),
    .bus       (bus0.slave),
    .dbg_state (st_o[0])
  );

  dmem_resp #(.WAIT_CYC(3)) u_dut3 (
    .CLK       (clk),
    .RSTn      (rstn),
    .bus       (bus1.slave),
    .dbg_state (st_o[1])
  );

  // Clock and READY pulse monitors
  always #5 clk = ~clk;
  always @(negedge clk) if (rdy[0] === 1'b1) pulses[0]++;
  always @(negedge clk) if (rdy[1] === 1'b1) pulses[1]++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int op, input logic [31:0] addr, input logic [31:0] din,
                     input logic [3:0] be, input logic e_err, input logic [31:0] e_dout);
    vt[nv] = '{op, addr, din, be, e_err, e_dout};
    nv++;
  endtask

  // Drive one request on instance s, hold it (optionally scrambled while busy), check the response.
  task automatic req(input int s, input int op, input logic [31:0] addr, input logic [31:0] din,
                     input logic [3:0] be, input logic e_err, input logic [31:0] e_dout,
                     input bit toggle, input string name);
    logic [32:0] e;
    int          cyc;
    bit          got;
    @(negedge clk);
    rd_d[s]   = (op != OP_W);
    w_d[s]    = (op != OP_RD);
    addr_d[s] = addr;
    din_d[s]  = din;
    be_d[s]   = be;
    exp_q.push_back({e_err, e_dout});
    exp_pulses[s]++;
    @(posedge clk);
    cyc = 0;
    got = 0;
    while (!got && cyc < 32) begin
      @(negedge clk);
      cyc++;
      if (rdy[s] === 1'b1) got = 1;
      else if (toggle) begin
        rd_d[s]   = 1'($urandom_range(0, 1));
        w_d[s]    = 1'($urandom_range(0, 1));
        addr_d[s] = $urandom;
        din_d[s]  = $urandom;
      end
    end
    e = exp_q.pop_front();
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: no READY within %0d cycles", name, cyc);
    end else begin
      chk({name, " err"}, 32'(err_o[s]), 32'(e[32]));
      chk({name, " dout"}, dout_o[s], e[31:0]);
      chk({name, " latency"}, 32'(cyc), 32'(LAT[s]));
    end
    rd_d[s] = 1'b0;
    w_d[s]  = 1'b0;
    @(negedge clk);
    chk({name, " ready width"}, 32'(rdy[s]), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rd_d[s] = 0; w_d[s] = 0; addr_d[s] = '0; din_d[s] = '0; be_d[s] = 4'hF;
    end

    add(OP_W,    32'h1001_0000, 32'h0BAD_F00D, 4'hF, 0, 32'h0000_0000);
    add(OP_W,    32'h1001_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0000);
    add(OP_RD,   32'h1001_0010, 32'h0,         4'hF, 0, 32'hDEAD_BEEF);
    add(OP_W,    32'h1001_03FC, 32'hCAFE_0001, 4'hF, 0, 32'hDEAD_BEEF);
    add(OP_RD,   32'h1001_03FC, 32'h0,         4'hF, 0, 32'hCAFE_0001);
    add(OP_W,    32'h1001_0002, 32'h1111_1111, 4'hF, 1, 32'hCAFE_0001);
    add(OP_RD,   32'h1001_0400, 32'h0,         4'hF, 1, 32'hCAFE_0001);
    add(OP_RD,   32'h1000_FFFC, 32'h0,         4'hF, 1, 32'hCAFE_0001);
    add(OP_W,    32'h1001_0400, 32'h2222_2222, 4'hF, 1, 32'hCAFE_0001);
    add(OP_RD,   32'h1001_0000, 32'h0,         4'hF, 0, 32'h0BAD_F00D);
    add(OP_BOTH, 32'h1001_0000, 32'h3333_3333, 4'hF, 1, 32'h0BAD_F00D);
    add(OP_RD,   32'h1001_0000, 32'h0,         4'hF, 0, 32'h0BAD_F00D);
    add(OP_W,    32'h1001_0014, 32'hAAAA_5555, 4'hF, 0, 32'h0BAD_F00D);
    add(OP_RD,   32'h1001_0014, 32'h0,         4'hF, 0, 32'hAAAA_5555);
    add(OP_RD,   32'h1001_0001, 32'h0,         4'hF, 1, 32'hAAAA_5555);
    add(OP_RD,   32'hFFFF_FFFC, 32'h0,         4'hF, 1, 32'hAAAA_5555);
`ifdef DMEM_RESP_BE_EN
    add(OP_W,    32'h1001_0020, 32'hFFFF_FFFF, 4'hF, 0, 32'hAAAA_5555);
    add(OP_W,    32'h1001_0020, 32'h0000_0000, 4'h5, 0, 32'hAAAA_5555);
    add(OP_RD,   32'h1001_0020, 32'h0,         4'hF, 0, 32'hFF00_FF00);
    add(OP_W,    32'h1001_0020, 32'h1234_5678, 4'h0, 1, 32'hFF00_FF00);
    add(OP_RD,   32'h1001_0020, 32'h0,         4'h0, 0, 32'hFF00_FF00);
`endif

    // Reset values
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset ready u%0d", s), 32'(rdy[s]), 32'd0);
      chk($sformatf("reset err u%0d", s), 32'(err_o[s]), 32'd0);
      chk($sformatf("reset dout u%0d", s), dout_o[s], 32'd0);
      chk($sformatf("reset state u%0d", s), 32'(st_o[s]), 32'(ST_IDLE));
    end
    rstn = 1'b1;

    for (int i = 0; i < nv; i++)
      req(0, vt[i].op, vt[i].addr, vt[i].din, vt[i].be, vt[i].exp_err, vt[i].exp_dout,
          0, $sformatf("vec%0d", i));

    // Store to word 5 aborted by reset while waiting
    @(negedge clk);
    w_d[0] = 1'b1; addr_d[0] = 32'h1001_0014; din_d[0] = 32'h1234_5678; be_d[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk("abort in wait state", 32'(st_o[0]), 32'(ST_WAIT));
    rstn = 1'b0;
    w_d[0] = 1'b0;
    @(negedge clk);
    chk("abort state", 32'(st_o[0]), 32'(ST_IDLE));
    chk("abort ready", 32'(rdy[0]), 32'd0);
    chk("abort dout", dout_o[0], 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort no late ready", 32'(rdy[0]), 32'd0);
    req(0, OP_RD, 32'h1001_0014, 32'h0, 4'hF, 0, 32'hAAAA_5555, 0, "abort readback");

    // Three wait states, requester inputs scrambled while busy
    req(1, OP_W,  32'h1001_0008, 32'h5A5A_A5A5, 4'hF, 0, 32'h0000_0000, 0, "w3 store");
    req(1, OP_RD, 32'h1001_0008, 32'h0,         4'hF, 0, 32'h5A5A_A5A5, 1, "w3 load busy");
    req(1, OP_RD, 32'h1001_000A, 32'h0,         4'hF, 1, 32'h5A5A_A5A5, 1, "w3 misaligned");
    req(1, OP_RD, 32'h1001_0008, 32'h0,         4'hF, 0, 32'h5A5A_A5A5, 0, "w3 reload");

    repeat (3) @(negedge clk);
    chk("ready pulses u1", 32'(pulses[0]), 32'(exp_pulses[0]));
    chk("ready pulses u3", 32'(pulses[1]), 32'(exp_pulses[1]));
    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
Synthesizable data-memory responder for the RISC_V core's load/store port, the target side of the core's RD_MEM/W_MEM/Z_ALU_MEM/RS2_MEM interface.
- Decodes the byte address against a base and checks alignment and range.
- Applies a fixed number of wait states, then completes with a one-cycle READY/ERR response.
- Replaces the behavioural DMEM model in gate-level and FPGA builds.

Parameters:
DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (256 words)
BASE_ADDR, 32'h1001_0000, byte address of word 0
WAIT_CYC, 1, wait states between request capture and response (0..15)

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  reset, synchronous, active-low
RD  in  1  load request, held by requester until READY
W  in  1  store request, held by requester until READY
ADDR  in  32  byte address (ALU result)
DIN  in  32  store data
DOUT  out  32  load data, valid with READY on a successful load
READY  out  1  one-cycle completion pulse
ERR  out  1  one-cycle error pulse, coincident with READY

Behaviour:
- Clock and reset: one clock, CLK. RSTn is synchronous and active-low: sampled only on the rising edge of CLK.
- Reset values: state=IDLE, wait counter=0, READY=0, ERR=0, DOUT=0. RAM contents are not reset.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: when RD|W is sampled high, capture ADDR, DIN and op (W has priority in the capture), then go to WAIT. If WAIT_CYC=0, go directly to DONE.
  - WAIT: counter increments each cycle. When counter==WAIT_CYC-1, go to DONE.
  - DONE: assert READY for exactly this cycle, then return to IDLE.
- Latency: request sampled at edge N -> READY high in cycle N+WAIT_CYC+1.
- Address decode: off = captured ADDR - BASE_ADDR (32-bit modular arithmetic).
  - idx = off[DEPTH_LOG2+1:2].
  - Error conditions:
    - ADDR[1:0]!=0 (misaligned);
    - off[31:DEPTH_LOG2+2]!=0, which includes ADDR below BASE_ADDR through wrap-around;
    - RD and W both high at capture.
- Error response: in DONE, assert ERR with READY. There is no RAM write and DOUT is unchanged.
- Store: RAM[idx] is written on the DONE-cycle edge. DOUT is unchanged.
- Load: DOUT is registered with RAM[idx] so it is valid during DOUT. DOUT then holds until the next successful load.
- Busy behaviour: RD/W changes during WAIT or DONE are ignored. The captured request is final.
- Back-to-back requests: a request still high in the cycle after READY is treated as a new request. The requester must drop RD/W on the edge that samples READY.
- Address boundary: the highest address BASE_ADDR+4*(2^DEPTH_LOG2-1) is valid. +4 beyond it is an error.
- Reset mid-operation: RSTn low in WAIT or DONE aborts to IDLE. No write occurs, and no READY is issued.

Optional Feature:
DMEM_RESP_BE_EN
- With the macro: adds input BE[3:0], captured with the request. A store writes only the bytes whose BE bit is 1. BE=0000 with W is an error. Loads ignore BE.
- Without the macro: there is no BE port, and every store writes the full 32-bit word.

Decomposition:
- Package dmem_resp_pkg holds:
  - state enum (IDLE, WAIT, DONE);
  - default BASE_ADDR and DEPTH_LOG2;
  - word width constant 32.
- Sub-module dmem_ram is a single-port synchronous RAM (write enable, optional byte lanes, registered read) so that vendor macros can be substituted.
- The FSM, decode and counter stay in dmem_resp.

Test Plan:
1. WAIT_CYC=1: W, ADDR=0x1001_0010, DIN=0xDEAD_BEEF; then RD at the same address -> READY 2 cycles after each capture, ERR=0, DOUT=0xDEAD_BEEF on the load.
2. WAIT_CYC=3: RD held -> READY exactly 4 cycles after capture. RD toggled during WAIT -> ignored, still exactly one READY pulse.
3. ADDR=0x1001_0002 store; ADDR=0x1001_0400 load; ADDR=0x1000_FFFC load -> each gives READY=ERR=1, and RAM/DOUT are unchanged (verified by read-back of word 0).
4. RD=W=1, ADDR=0x1001_0000 -> ERR=1, and word 0 keeps its prior value.
5. Store 0x1234_5678 to word 5, with RSTn pulsed low during WAIT -> no READY. Subsequent load of word 5 returns the old value, and outputs are 0 after reset.
6. With DMEM_RESP_BE_EN: word=0xFFFF_FFFF, store DIN=0x0000_0000 with BE=0101 -> load returns 0xFF00_FF00. BE=0000 -> ERR=1.
